// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA-256 UART front end.
package rsa_pkg;

  // Controller states.
  typedef enum logic [2:0] {
    S_QUERY_RX  = 3'd0,
    S_READ      = 3'd1,
    S_WAIT_CORE = 3'd2,
    S_QUERY_TX  = 3'd3,
    S_WRITE     = 3'd4
  } state_t;

  // Which 256-bit operand the incoming bytes are loading.
  typedef enum logic [1:0] {
    PH_N = 2'd0,
    PH_D = 2'd1,
    PH_A = 2'd2
  } phase_t;

  // UART controller register map and status bit positions.
  localparam logic [4:0] RX_BASE     = 5'd0;
  localparam logic [4:0] TX_BASE     = 5'd4;
  localparam logic [4:0] STATUS_BASE = 5'd8;
  localparam int         RX_RDY_BIT  = 7;
  localparam int         TX_RDY_BIT  = 6;

  // Bytes per operand received, and plaintext bytes sent back.
  localparam int KEY_BYTES = 32;
  localparam int OUT_BYTES = 31;

endpackage

// File: rtl/rsa256_uart_wrapper.sv
// Avalon-MM master that loads n, d and ciphertext from a polled UART,
// kicks the RSA-256 core and streams the 31-byte plaintext back out.
module rsa256_uart_wrapper #(
  parameter logic [4:0] RX_BASE     = rsa_pkg::RX_BASE,
  parameter logic [4:0] TX_BASE     = rsa_pkg::TX_BASE,
  parameter logic [4:0] STATUS_BASE = rsa_pkg::STATUS_BASE,
  parameter int         RX_RDY_BIT  = rsa_pkg::RX_RDY_BIT,
  parameter int         TX_RDY_BIT  = rsa_pkg::TX_RDY_BIT
) (
  input  logic         i_clk,
  input  logic         i_rst,
  output logic [4:0]   o_avm_address,
  output logic         o_avm_read,
  input  logic [31:0]  i_avm_readdata,
  output logic         o_avm_write,
  output logic [31:0]  o_avm_writedata,
  input  logic         i_avm_waitrequest,
  output logic         o_core_start,
  output logic [255:0] o_core_n,
  output logic [255:0] o_core_d,
  output logic [255:0] o_core_a,
  input  logic [255:0] i_core_a_pow_d,
  input  logic         i_core_finished
);

  import rsa_pkg::*;

  state_t       r_state;
  phase_t       r_phase;
  logic [5:0]   r_cnt;
  logic [255:0] r_n;
  logic [255:0] r_d;
  logic [255:0] r_a;
  logic [255:0] r_out;
  logic [4:0]   r_addr;
  logic         r_read;
  logic         r_write;
  logic [7:0]   r_wbyte;
  logic         r_start;

  logic         w_accept;
  logic         w_last_key;
  logic         w_last_out;

  assign w_accept   = (r_read | r_write) && !i_avm_waitrequest;
  assign w_last_key = (r_cnt == 6'(KEY_BYTES - 1));
  assign w_last_out = (r_cnt == 6'(OUT_BYTES - 1));

  assign o_avm_address   = r_addr;
  assign o_avm_read      = r_read;
  assign o_avm_write     = r_write;
  assign o_avm_writedata = {24'b0, r_wbyte};
  assign o_core_start    = r_start;
  assign o_core_n        = r_n;
  assign o_core_d        = r_d;
  assign o_core_a        = r_a;

  // Polling FSM: bus outputs move only on an accept edge or a state change.
  // NOTE: every register here uses <= so all branches see pre-edge values;
  // blocking assignments would let later statements observe half-updated state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_QUERY_RX;
      r_phase <= PH_N;
      r_cnt   <= '0;
      r_n     <= '0;
      r_d     <= '0;
      r_a     <= '0;
      r_out   <= '0;
      r_addr  <= STATUS_BASE;
      r_read  <= 1'b1;
      r_write <= 1'b0;
      r_wbyte <= '0;
      r_start <= 1'b0;
    end else begin
      r_start <= 1'b0;
      unique case (r_state)
        S_QUERY_RX: begin
          if (w_accept && i_avm_readdata[RX_RDY_BIT]) begin
            r_state <= S_READ;
            r_addr  <= RX_BASE;
          end
        end
        S_READ: begin
          if (w_accept) begin
            unique case (r_phase)
              PH_N:    r_n <= {r_n[247:0], i_avm_readdata[7:0]};
              PH_D:    r_d <= {r_d[247:0], i_avm_readdata[7:0]};
              default: r_a <= {r_a[247:0], i_avm_readdata[7:0]};
            endcase
            if (w_last_key) begin
              r_cnt <= '0;
              if (r_phase == PH_A) begin
                // Ciphertext complete: release the bus and fire the core.
                r_state <= S_WAIT_CORE;
                r_read  <= 1'b0;
                r_start <= 1'b1;
              end else begin
                r_phase <= (r_phase == PH_N) ? PH_D : PH_A;
                r_state <= S_QUERY_RX;
                r_addr  <= STATUS_BASE;
              end
            end else begin
              r_cnt   <= r_cnt + 6'd1;
              r_state <= S_QUERY_RX;
              r_addr  <= STATUS_BASE;
            end
          end
        end
        S_WAIT_CORE: begin
          // A finished level left over from the previous run is ignored
          // during the start cycle itself.
          if (!r_start && i_core_finished) begin
            r_out   <= i_core_a_pow_d;
            r_state <= S_QUERY_TX;
            r_addr  <= STATUS_BASE;
            r_read  <= 1'b1;
          end
        end
        S_QUERY_TX: begin
          if (w_accept && i_avm_readdata[TX_RDY_BIT]) begin
            r_state <= S_WRITE;
            r_read  <= 1'b0;
            r_write <= 1'b1;
            r_addr  <= TX_BASE;
            r_wbyte <= r_out[247:240];
          end
        end
        S_WRITE: begin
          if (w_accept) begin
            r_out   <= {r_out[247:0], 8'h00};
            r_write <= 1'b0;
            r_read  <= 1'b1;
            r_addr  <= STATUS_BASE;
            if (w_last_out) begin
              // Keys stay loaded; only a new ciphertext is fetched next.
              r_cnt   <= '0;
              r_phase <= PH_A;
              r_state <= S_QUERY_RX;
            end else begin
              r_cnt   <= r_cnt + 6'd1;
              r_state <= S_QUERY_TX;
            end
          end
        end
        default: r_state <= S_QUERY_RX;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa256_uart_wrapper.sv
// Scoreboard bench: a UART/core model answers the bus, expectations are
// queued at stimulus time and retired when the DUT pulses start or writes TX.
module tb_rsa256_uart_wrapper;
  import rsa_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [4:0]   avm_address;
  logic         avm_read;
  logic [31:0]  avm_rdata;
  logic         avm_write;
  logic [31:0]  avm_wdata;
  logic         avm_wait;
  logic         core_start;
  logic [255:0] core_n, core_d, core_a;
  logic [255:0] core_pow;
  logic         core_fin;

  always #5 clk = ~clk;

  rsa256_uart_wrapper dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .o_avm_address     (avm_address),
    .o_avm_read        (avm_read),
    .i_avm_readdata    (avm_rdata),
    .o_avm_write       (avm_write),
    .o_avm_writedata   (avm_wdata),
    .i_avm_waitrequest (avm_wait),
    .o_core_start      (core_start),
    .o_core_n          (core_n),
    .o_core_d          (core_d),
    .o_core_a          (core_a),
    .i_core_a_pow_d    (core_pow),
    .i_core_finished   (core_fin)
  );

  typedef struct {
    logic [255:0] n;
    logic [255:0] d;
    logic [255:0] a;
  } keys_t;

  int errors = 0;
  int checks = 0;

  logic [7:0]   rx_q[$];
  logic [7:0]   exp_tx[$];
  logic [255:0] core_q[$];
  keys_t        exp_start[$];

  bit  stall_en     = 1'b0;
  int  rx_hold      = 0;
  int  pending_hold = 0;
  int  status_cnt   = 0;
  bit  check_poll   = 1'b0;
  int  cyc          = 0;
  int  start_cyc    = 0;
  int  starts_seen  = 0;
  int  tx_count     = 0;
  int  rx_reads     = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Operand whose bytes are first, first+1, ... with the first byte as MSB.
  function automatic logic [255:0] seq_value(input int first);
    logic [255:0] v;
    for (int i = 0; i < 32; i++) v[8*(31-i) +: 8] = 8'(first + i);
    return v;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Queue the 32 UART bytes of an operand, most significant byte first.
  task automatic push_block(input logic [255:0] v);
    for (int i = 0; i < 32; i++) rx_q.push_back(v[8*(31-i) +: 8]);
  endtask

  // Queue a core result and the 31 bytes expected on TX (top byte never sent).
  task automatic push_result(input logic [255:0] v);
    core_q.push_back(v);
    for (int k = 30; k >= 0; k--) exp_tx.push_back(v[8*k +: 8]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"},  avm_address, STATUS_BASE);
    check({tag, "_read"},  avm_read, 1'b1);
    check({tag, "_write"}, avm_write, 1'b0);
    check({tag, "_wdata"}, avm_wdata, 32'h0);
    check({tag, "_start"}, core_start, 1'b0);
    check({tag, "_n"},     core_n, 256'h0);
    check({tag, "_d"},     core_d, 256'h0);
    check({tag, "_a"},     core_a, 256'h0);
  endtask

  task automatic wait_tx(input int target, input int limit, input string name);
    int i = 0;
    while (tx_count < target && i < limit) begin
      @(negedge clk);
      i++;
    end
    check(name, 256'(tx_count >= target), 1'b1);
  endtask

  // UART slave, core model and monitor, all evaluated away from the active edge.
  initial begin
    logic [38:0] prev_bus;
    bit    prev_stalled = 1'b0;
    bit    prev_start   = 1'b0;
    bit    busy = 1'b0, drop_next = 1'b0, corrupt_next = 1'b0;
    int    fin_cnt = 0;
    keys_t cur;
    prev_bus = '0;
    avm_wait = 1'b1;
    avm_rdata = '0;
    core_fin = 1'b0;
    core_pow = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        avm_wait = 1'b1;
        cyc = 0;
        prev_stalled = 1'b0;
        prev_start = 1'b0;
        busy = 1'b0;
        drop_next = 1'b0;
        corrupt_next = 1'b0;
        core_fin = 1'b0;
      end else begin
        cyc++;
        if (prev_stalled)
          check("stall_hold", {avm_address, avm_read, avm_write, avm_wdata}, prev_bus);
        check("rd_wr_excl", avm_read & avm_write, 1'b0);

        // Core model: result appears 10 cycles after start, input changes afterwards.
        if (corrupt_next) begin
          core_pow = rand256();
          corrupt_next = 1'b0;
        end
        if (drop_next) begin
          core_fin = 1'b0;
          drop_next = 1'b0;
        end
        if (busy) begin
          check("n_stable", core_n, cur.n);
          check("d_stable", core_d, cur.d);
          check("a_stable", core_a, cur.a);
          fin_cnt--;
          if (fin_cnt == 0) begin
            check("core_q_avail", 256'(core_q.size() > 0), 1'b1);
            if (core_q.size() > 0) core_pow = core_q.pop_front();
            core_fin = 1'b1;
            busy = 1'b0;
            corrupt_next = 1'b1;
          end
        end
        if (core_start) begin
          starts_seen++;
          start_cyc = cyc;
          check("single_pulse", prev_start, 1'b0);
          check("start_expected", 256'(exp_start.size() > 0), 1'b1);
          if (exp_start.size() > 0) begin
            cur = exp_start.pop_front();
            check("start_n", core_n, cur.n);
            check("start_d", core_d, cur.d);
            check("start_a", core_a, cur.a);
          end
          busy = 1'b1;
          fin_cnt = 10;
          drop_next = 1'b1;
        end
        prev_start = core_start;

        // UART slave response for the upcoming edge.
        avm_wait = stall_en ? ($urandom_range(0, 1) == 1) : 1'b0;
        avm_rdata = $urandom;
        if (avm_read && avm_address == STATUS_BASE) begin
          avm_rdata[RX_RDY_BIT] = (rx_q.size() > 0) && (rx_hold == 0);
          avm_rdata[TX_RDY_BIT] = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end else if (avm_read && avm_address == RX_BASE && rx_q.size() > 0) begin
          avm_rdata[7:0] = rx_q[0];
        end

        if (!avm_wait && (avm_read || avm_write)) begin
          if (avm_read) begin
            if (avm_address == STATUS_BASE) begin
              status_cnt++;
              if (rx_hold > 0) rx_hold--;
            end else begin
              check("rx_addr", avm_address, RX_BASE);
              check("rx_avail", 256'(rx_q.size() > 0), 1'b1);
              if (rx_q.size() > 0) void'(rx_q.pop_front());
              rx_reads++;
              if (check_poll) check("poll_count", status_cnt, 6);
              check_poll = 1'b0;
              status_cnt = 0;
            end
          end else begin
            check("tx_addr", avm_address, TX_BASE);
            check("tx_expected", 256'(exp_tx.size() > 0), 1'b1);
            if (exp_tx.size() > 0) check("tx_data", avm_wdata, {24'b0, exp_tx.pop_front()});
            tx_count++;
            status_cnt = 0;
            if ((tx_count % OUT_BYTES) == 0 && pending_hold > 0) begin
              rx_hold = pending_hold;
              pending_hold = 0;
              check_poll = 1'b1;
            end
          end
        end
        prev_bus = {avm_address, avm_read, avm_write, avm_wdata};
        prev_stalled = avm_wait && (avm_read || avm_write);
      end
    end
  end

  // Stimulus.
  initial begin
    logic [255:0] n1, d1, a1, a2, n3, d3;
    int i;
    n1 = seq_value(8'h01);
    d1 = seq_value(8'h21);
    a1 = seq_value(8'h41);
    a2 = seq_value(8'h61);

    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");

    // Run 1: no stalls, RX always ready, fixed core result.
    push_block(n1);
    push_block(d1);
    push_block(a1);
    exp_start.push_back('{n: n1, d: d1, a: a1});
    push_result({8'h00, {31{8'hAA}}});
    @(negedge clk);
    #1 rst = 1'b0;

    i = 0;
    while (starts_seen < 1 && i < 2000) begin
      @(negedge clk);
      i++;
    end
    check("start1_seen", starts_seen, 1);
    check("start_latency", start_cyc, 193);

    // Run 2: second ciphertext, 5 not-ready polls, random stalls.
    push_block(a2);
    exp_start.push_back('{n: n1, d: d1, a: a2});
    push_result(rand256());
    pending_hold = 5;
    stall_en = 1'b1;
    wait_tx(62, 20000, "tx_done_run2");
    check("start_count", starts_seen, 2);
    check("n_kept", core_n, n1);
    check("d_kept", core_d, d1);

    // Run 3: reset while d is partially loaded.
    @(negedge clk);
    #2 rst = 1'b1;
    rx_q.delete();
    exp_start.delete();
    exp_tx.delete();
    core_q.delete();
    rx_reads = 0;
    tx_count = 0;
    starts_seen = 0;
    status_cnt = 0;
    check_poll = 1'b0;
    rx_hold = 0;
    n3 = rand256();
    d3 = rand256();
    push_block(n3);
    for (int k = 0; k < 17; k++) rx_q.push_back(d3[8*(31-k) +: 8]);
    @(negedge clk);
    #1 rst = 1'b0;
    i = 0;
    while (rx_reads < 49 && i < 5000) begin
      @(negedge clk);
      i++;
    end
    check("partial_reads", rx_reads, 49);
    repeat (4) @(negedge clk);
    check("partial_n", core_n, n3);
    check("partial_d", core_d, d3 >> (15 * 8));

    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    rx_q.delete();
    tx_count = 0;
    starts_seen = 0;
    push_block(n1);
    push_block(d1);
    push_block(a1);
    exp_start.push_back('{n: n1, d: d1, a: a1});
    push_result(rand256());
    @(negedge clk);
    #1 rst = 1'b0;
    wait_tx(31, 20000, "tx_done_run3");
    check("start_count3", starts_seen, 1);
    check("final_n", core_n, n1);
    check("final_d", core_d, d1);
    check("final_a", core_a, a1);

    repeat (5) @(negedge clk);
    check("start_q_empty", exp_start.size(), 0);
    check("tx_q_empty", exp_tx.size(), 0);
    check("rx_q_empty", rx_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
